// File: rtl/div_seq_pkg.sv
// Shared definitions for the signed 4-bit division sequencer.
// Contents:
//   DataW / CmpLatDefault / DivSteps  default sizing and timing constants
//   div_state_e                       sequencer state encoding (3 bits)
//   Div0Quotient                      quotient reported for a zero divisor
//   is_ovf()                          detects the single overflowing case -8 / -1
package div_seq_pkg;

    localparam int unsigned DataW         = 4;
    localparam int unsigned CmpLatDefault = 2;
    localparam int unsigned DivSteps      = 4;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StNegReq  = 3'd1,
        StNegWait = 3'd2,
        StDiv     = 3'd3,
        StFixReq  = 3'd4,
        StFixWait = 3'd5,
        StDone    = 3'd6
    } div_state_e;

    // Divide by zero: quotient is all ones, remainder echoes the dividend.
    localparam logic [DataW-1:0] Div0Quotient = 4'b1111;
    localparam logic [DataW-1:0] MinNeg       = 4'b1000;
    localparam logic [DataW-1:0] MinusOne     = 4'b1111;

    function automatic logic is_ovf(input logic [DataW-1:0] a, input logic [DataW-1:0] b);
        return (a == MinNeg) && (b == MinusOne);
    endfunction

endpackage

// File: rtl/division_restoring_core.sv
// Unsigned restoring divider, one quotient bit per step, MSB first.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   load_i                capture dividend_i / divisor_i and clear the partial remainder
//   step_i                perform one shift/trial-subtract step (ignored once valid_o is high)
//   dividend_i, divisor_i unsigned magnitudes (divisor must be non-zero)
//   quotient_next_o       quotient register value after the current step
//   remainder_next_o      remainder value after the current step
//   last_step_o           the current step is the final one; *_next_o hold the result
//   valid_o               all steps done since the last load
module division_restoring_core
    import div_seq_pkg::*;
#(
    parameter int unsigned W     = DataW,
    parameter int unsigned Steps = DivSteps
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         step_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] quotient_next_o,
    output logic [W-1:0] remainder_next_o,
    output logic         last_step_o,
    output logic         valid_o
);

    localparam int unsigned  CntW = $clog2(Steps);
    localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

    // dvd_q shifts the dividend out of its MSB while quotient bits enter at the LSB.
    logic [W-1:0]    dvd_q, dvd_d;
    logic [W-1:0]    dvs_q, dvs_d;
    logic [W-1:0]    rem_q, rem_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            valid_q, valid_d;

    logic [W:0]   pr;
    logic [W-1:0] diff;
    logic         fits;
    logic         do_step;

    always_comb begin
        pr   = {rem_q, dvd_q[W-1]};
        fits = (pr >= {1'b0, dvs_q});
        // When the trial fits the true difference is below the divisor, so W bits suffice.
        diff = pr[W-1:0] - dvs_q;
        quotient_next_o  = {dvd_q[W-2:0], fits};
        remainder_next_o = fits ? diff : pr[W-1:0];
    end

    assign do_step     = step_i && !valid_q;
    assign last_step_o = do_step && (cnt_q == LastCnt);
    assign valid_o     = valid_q;

    always_comb begin
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load_i) begin
            dvd_d   = dividend_i;
            dvs_d   = divisor_i;
            rem_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else if (do_step) begin
            dvd_d   = quotient_next_o;
            rem_d   = remainder_next_o;
            cnt_d   = cnt_q + CntW'(1);
            valid_d = (cnt_q == LastCnt);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/division_sequencer.sv
// Signed 4-bit divider sequencer. Takes operand magnitudes through the shared
// two's-complement stage, runs the restoring core, then negates the quotient
// and/or remainder through the same stage when the signs call for it.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   start, dividend, divisor      request and signed operands (sampled when idle)
//   busy, done                    busy from accept until done clears; done is a 1-cycle pulse
//   quotient, remainder           signed results, held until the next completion
//   err_div0, ovf                 zero divisor / -8 by -1 flags, valid with done
//   cmp_sel, cmp_first, cmp_second     request and operands to the complement stage
//   cmp_res_first, cmp_res_second      complemented values from the stage
//   cmp_finish                    stage finish flag (sticky once set)
// Only W = 4 is supported: the complement stage is fixed at 4 bits.
module division_sequencer
    import div_seq_pkg::*;
#(
    parameter int unsigned W       = DataW,
    parameter int unsigned CMP_LAT = CmpLatDefault
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         err_div0,
    output logic         ovf,
    output logic         cmp_sel,
    output logic [W-1:0] cmp_first,
    output logic [W-1:0] cmp_second,
    input  logic [W-1:0] cmp_res_first,
    input  logic [W-1:0] cmp_res_second,
    input  logic         cmp_finish
);

    localparam logic [7:0] LatCnt = 8'(CMP_LAT);

    div_state_e   state_q, state_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         sel_q, sel_d;
    logic [W-1:0] first_q, first_d;
    logic [W-1:0] second_q, second_d;
    logic [W-1:0] quot_q, quot_d;
    logic [W-1:0] rem_q, rem_d;
    logic         err_q, err_d;
    logic         ovf_q, ovf_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic         sa_q, sa_d;
    logic         sb_q, sb_d;
    logic         nq_q, nq_d;
    logic         nr_q, nr_d;
    logic [7:0]   cnt_q, cnt_d;

    logic [W-1:0] ma, mb, core_a, core_b, qm, rm;
    logic         core_load, core_step, core_last, core_valid;
    logic         nq, nr, accept, wait_exit;
    logic [7:0]   cnt_inc;

    assign ma     = sa_q ? cmp_res_first : a_q;
    assign mb     = sb_q ? cmp_res_second : b_q;
    // Unsigned operands go straight from the request; signed ones wait for the stage.
    assign core_a = (state_q == StIdle) ? dividend : ma;
    assign core_b = (state_q == StIdle) ? divisor : mb;

    assign nq = (sa_q ^ sb_q) && (qm != '0);
    assign nr = sa_q && (rm != '0);

    assign accept  = (state_q == StIdle) && start && !busy_q;
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    // cnt_inc counts the wait cycle in progress; the floor keeps a stale sticky
    // finish from being taken as completion of the pass just requested.
    assign wait_exit = cmp_finish && (cnt_inc >= LatCnt);

    division_restoring_core #(
        .W    (W),
        .Steps(DivSteps)
    ) u_core (
        .clk_i           (clk),
        .rst_ni          (rst),
        .load_i          (core_load),
        .step_i          (core_step),
        .dividend_i      (core_a),
        .divisor_i       (core_b),
        .quotient_next_o (qm),
        .remainder_next_o(rm),
        .last_step_o     (core_last),
        .valid_o         (core_valid)
    );

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sel_d     = 1'b0;
        first_d   = first_q;
        second_d  = second_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        err_d     = err_q;
        ovf_d     = ovf_q;
        a_d       = a_q;
        b_d       = b_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        nq_d      = nq_q;
        nr_d      = nr_q;
        cnt_d     = cnt_q;
        core_load = 1'b0;
        core_step = 1'b0;

        case (state_q)
            StIdle: begin
                // busy stays up through the done cycle and drops with it.
                busy_d = 1'b0;
                if (accept) begin
                    busy_d = 1'b1;
                    a_d    = dividend;
                    b_d    = divisor;
                    sa_d   = dividend[W-1];
                    sb_d   = divisor[W-1];
                    if (divisor == '0) begin
                        state_d = StDone;
                        quot_d  = Div0Quotient;
                        rem_d   = dividend;
                        err_d   = 1'b1;
                        ovf_d   = 1'b0;
                    end else if (dividend[W-1] || divisor[W-1]) begin
                        state_d  = StNegReq;
                        sel_d    = 1'b1;
                        first_d  = dividend;
                        second_d = divisor;
                    end else begin
                        state_d   = StDiv;
                        core_load = 1'b1;
                    end
                end
            end
            StNegReq: begin
                cnt_d   = '0;
                state_d = StNegWait;
            end
            StNegWait: begin
                if (wait_exit) begin
                    state_d   = StDiv;
                    core_load = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StDiv: begin
                core_step = !core_valid;
                if (core_last) begin
                    if (nq || nr) begin
                        state_d  = StFixReq;
                        sel_d    = 1'b1;
                        first_d  = qm;
                        second_d = rm;
                        nq_d     = nq;
                        nr_d     = nr;
                    end else begin
                        state_d = StDone;
                        quot_d  = qm;
                        rem_d   = rm;
                        err_d   = 1'b0;
                        ovf_d   = is_ovf(a_q, b_q);
                    end
                end
            end
            StFixReq: begin
                cnt_d   = '0;
                state_d = StFixWait;
            end
            StFixWait: begin
                if (wait_exit) begin
                    state_d = StDone;
                    quot_d  = nq_q ? cmp_res_first : first_q;
                    rem_d   = nr_q ? cmp_res_second : second_q;
                    err_d   = 1'b0;
                    ovf_d   = is_ovf(a_q, b_q);
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sel_q    <= 1'b0;
            first_q  <= '0;
            second_q <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            nq_q     <= 1'b0;
            nr_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sel_q    <= sel_d;
            first_q  <= first_d;
            second_q <= second_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            nq_q     <= nq_d;
            nr_q     <= nr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign quotient   = quot_q;
    assign remainder  = rem_q;
    assign err_div0   = err_q;
    assign ovf        = ovf_q;
    assign cmp_sel    = sel_q;
    assign cmp_first  = first_q;
    assign cmp_second = second_q;

endmodule

// File: doc/division_sequencer.md
Name: division_sequencer

Overview:
Control FSM that performs one signed 4-bit division per request by sequencing the shared two's-complement stage (division_complement_to_2) and an internal restoring divider. Flow: operand sign capture → optional negation pass through the complement stage → 4-step unsigned division → optional result-fix pass through the same complement stage → result with done pulse. Sits between the calculator's operation decoder and the complement stage, and is that stage's only owner.

Parameters:
W, 4, operand/result width; the complement stage is fixed at 4, so W != 4 is unsupported.
CMP_LAT, 2, minimum cycles between a cmp_sel pulse and accepting cmp_finish; covers the stage's sticky finish flag.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  request, sampled in IDLE only.
dividend  input  W  signed two's-complement operand, captured when start is accepted.
divisor  input  W  signed operand, captured when start is accepted.
busy  output  1  high from the accept edge until the edge that clears done.
done  output  1  one-cycle pulse when results are valid.
quotient  output  W  signed quotient, held until the next accept.
remainder  output  W  signed remainder (sign of dividend), held until the next accept.
err_div0  output  1  divisor was zero; valid with done.
ovf  output  1  result is -8 / -1; valid with done.
cmp_sel  output  1  one-cycle request to the complement stage.
cmp_first  output  W  value driven to the stage's first_nr_reg.
cmp_second  output  W  value driven to the stage's second_nr_reg.
cmp_res_first  input  W  stage output first_nr.
cmp_res_second  input  W  stage output second_nr.
cmp_finish  input  1  stage complement1_finish; sticky level.

Behaviour:
- Reset (rst=0, async): state IDLE; busy, done, cmp_sel, err_div0, ovf = 0; quotient, remainder, cmp_first, cmp_second = 0; counters = 0.
- States: IDLE, NEG_REQ, NEG_WAIT, DIV, FIX_REQ, FIX_WAIT, DONE.
- IDLE:
  - start=1 → latch the operands and the sign bits sa=dividend[3], sb=divisor[3]; busy=1.
  - divisor==0 → DONE with err_div0=1, quotient=4'b1111, remainder=dividend.
  - sa|sb → NEG_REQ.
  - otherwise → DIV.
  - start while busy is ignored; there is no queue.
- NEG_REQ:
  - cmp_sel=1 for exactly one cycle; cmp_first=dividend, cmp_second=divisor.
  - cmp_first/cmp_second stay stable until the wait state exits.
  - Clear the wait counter, then → NEG_WAIT.
- NEG_WAIT:
  - Count cycles; exit when count ≥ CMP_LAT and cmp_finish=1.
  - Magnitudes: ma = sa ? cmp_res_first : dividend; mb = sb ? cmp_res_second : divisor. Unsigned 4-bit, so -8 gives magnitude 8 (4'b1000).
  - Then → DIV.
- DIV: restoring division, one bit per cycle, exactly 4 cycles, MSB first.
  - Partial remainder is 5 bits: shift in the next ma bit, trial-subtract mb, keep the result if non-negative, set the quotient bit accordingly.
- After DIV, with unsigned results qm and rm:
  - nq = sa^sb and qm != 0; nr = sa and rm != 0.
  - nq|nr → FIX_REQ, else → DONE.
- FIX_REQ / FIX_WAIT:
  - Same protocol as NEG_REQ/NEG_WAIT, with cmp_first=qm and cmp_second=rm.
  - quotient = nq ? cmp_res_first : qm; remainder = nr ? cmp_res_second : rm.
- Overflow: dividend=-8 and divisor=-1 → ovf=1, quotient=4'b1000 (wrapped), remainder=0.
- DONE: done=1 for one cycle, busy=0 on the following edge, → IDLE. Outputs hold.
- Latency from the accept edge to done high:
  - no negative operand, no fix: 5 cycles.
  - each complement pass adds 1 + max(CMP_LAT, finish delay) cycles.
- Sticky finish: because cmp_finish never falls after the first use, the CMP_LAT floor is mandatory. Never exit a wait state on the same edge as cmp_sel.
- Reset mid-operation: immediate return to IDLE; no partial results escape; done is not pulsed.

Decomposition:
- Package div_seq_pkg:
  - state encodings (3-bit localparams)
  - W = 4
  - CMP_LAT default
  - DIV_STEPS = 4
  - divide-by-zero constants: quotient 4'b1111, remainder = dividend
- One natural sub-module: division_restoring_core, the 4-cycle shift/subtract engine with load, step and valid signals. The FSM, sign logic and complement-stage handshake stay in division_sequencer.

Test Plan:
- 7 / 2, no negative operand → no cmp_sel; done 5 cycles after accept; quotient=0011, remainder=0001.
- -7 / 2 → one cmp_sel in the negation pass, magnitudes 7 and 2, then a fix pass; quotient=1101 (-3), remainder=1111 (-1), ovf=0.
- 6 / -3 → quotient=1110 (-2), remainder=0000; the fix pass negates only the quotient.
- 5 / 0 → no cmp_sel; done after 1 cycle; err_div0=1, quotient=1111, remainder=0101.
- -8 / -1 → ovf=1, quotient=1000, remainder=0000.
- Back-to-back operations with cmp_finish stuck high:
  - each wait lasts exactly CMP_LAT cycles;
  - start asserted while busy is ignored;
  - rst low during DIV clears busy, done and outputs asynchronously;
  - the next start after reset gives a correct result.
